mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_WORDS, default 512, number of implemented RAM words; addresses >= MEM_WORDS are out of range.
REQ-002 Clocking: one clock, clk; reset rst_n is asynchronous and active-low.
REQ-003 clk  in  1  system clock, all state on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 if_req  in  1  instruction-fetch read request, held until if_gnt.
REQ-006 if_addr  in  16  fetch word address.
REQ-007 if_gnt  out  1  fetch request accepted this cycle.
REQ-008 if_rvalid  out  1  fetch read data valid.
REQ-009 if_rdata  out  16  fetch read data.
REQ-010 if_err  out  1  fetch address out of range.
REQ-011 dm_req  in  1  data-port request (load or store), held until dm_gnt.
REQ-012 dm_we  in  1  1 = store, 0 = load.
REQ-013 dm_addr  in  16  data word address.
REQ-014 dm_wdata  in  16  store data.
REQ-015 dm_gnt / dm_rvalid / dm_rdata / dm_err  out  1/1/16/1  as if_* for data port.
REQ-016 ram_addr  out  16  to RAM addr_in.
REQ-017 ram_wdata  out  16  to RAM data_in.
REQ-018 ram_we  out  1  to RAM write_enable.
REQ-019 ram_rdata  in  16  from RAM data_out (registered, 1-cycle read latency).

Function
REQ-020 Each cycle with rst_n high, at most one request shall be granted; gnt is combinational from req in the same cycle N.
REQ-021 Granted in-range access: ram_addr = port addr, ram_we = dm_we (0 for fetch), ram_wdata = dm_wdata (0 for fetch) during cycle N.
REQ-022 With no grant: ram_addr = 0, ram_wdata = 0, ram_we = 0.
REQ-023 In-range read granted in N: port rvalid pulses 1 cycle in N+1, port rdata = ram_rdata in N+1.
REQ-024 rdata shall be 0 in any cycle its rvalid is 0.
REQ-025 Stores complete at gnt; no rvalid for stores.
REQ-026 Out-of-range request (addr >= MEM_WORDS): granted in N, RAM untouched (ram_we = 0), port err pulses in N+1, no rvalid.
REQ-027 Back-to-back grants every cycle shall be supported; pending-read owner tracked by registered state (NONE/IF/DM) updated each cycle.
REQ-028 Single requester: granted immediately, regardless of history.
REQ-029 Both requesting, priority per REQ-036/REQ-037; loser holds request and is not granted that cycle.
REQ-030 Load to address X in cycle N after store to X in cycle N-1 shall return the stored value.

Reset
REQ-031 rst_n low forces all gnt, rvalid, err to 0 immediately and ram_we to 0.
REQ-032 Reset clears pending-read state to NONE; a read granted before reset shall not produce rvalid after release.
REQ-033 Reset sets last-grant register to IF.
REQ-034 First clk edge after release may grant.

Configuration
REQ-035 Macro MEM_ARB_RR_EN selects arbitration policy.
REQ-036 Undefined: fixed priority, dm wins over if on conflict; if may starve.
REQ-037 Defined: round-robin, on conflict the port not granted last wins; last-grant updates only on granted cycles; first conflict after reset goes to dm.

Verification
REQ-038 dm store 0x1234 to 0x0005, next cycle dm load 0x0005 -> dm_gnt both cycles, dm_rvalid and dm_rdata = 0x1234 in load cycle + 1.
REQ-039 if_req and dm_req held 4 cycles, without MEM_ARB_RR_EN -> dm_gnt all 4, if_gnt 0; with it -> grants dm, if, dm, if.
REQ-040 if load 0x0200 with MEM_WORDS = 512 -> if_gnt, ram_we 0, if_err pulse next cycle, if_rvalid 0.
REQ-041 dm store 0xBEEF to 0x0300 -> dm_err next cycle; later load 0x0000 unaffected.
REQ-042 Read granted, rst_n low mid-cycle before next edge -> all outputs 0 at once, no rvalid after release.
REQ-043 Alternate if loads to 0x0000..0x0003 each cycle (pre-stored 0x0A00..0x0A03) -> if_rvalid every cycle from second, data in order.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction fetch / data) arbiter in front of a
// single-port RAM that has a 1-cycle registered read.
// Grants are combinational from the requests in the same cycle.
// Read data and error responses arrive one cycle after the grant.
// Optional macro MEM_ARB_RR_EN switches the arbitration policy.
//   Undefined: fixed priority, where the data port always wins.
//   Defined:   round-robin, where the port not granted last time wins.
module mem_arbiter #(
    parameter int MEM_WORDS = 512
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [15:0] if_rdata,
    output logic        if_err,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [15:0] dm_rdata,
    output logic        dm_err,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_wdata,
    output logic        ram_we,
    input  logic [15:0] ram_rdata
);

    localparam logic [16:0] MEM_LIMIT = 17'(MEM_WORDS);

    typedef enum logic [1:0] {
        PEND_NONE = 2'd0,
        PEND_IF   = 2'd1,
        PEND_DM   = 2'd2
    } pend_t;

    pend_t pend_q, pend_d;
    logic  if_err_q, if_err_d;
    logic  dm_err_q, dm_err_d;
    logic  if_in_range, dm_in_range;
    logic  if_win, dm_win;

    // Address range checks against the implemented RAM size
    always_comb begin
        if_in_range = ({1'b0, if_addr} < MEM_LIMIT);
        dm_in_range = ({1'b0, dm_addr} < MEM_LIMIT);
    end

`ifdef MEM_ARB_RR_EN
    typedef enum logic {
        LAST_IF = 1'b0,
        LAST_DM = 1'b1
    } last_t;

    last_t last_q, last_d;

    // Round-robin choice: on conflict the port that was not granted last wins
    always_comb begin
        if_win = 1'b0;
        dm_win = 1'b0;
        if (if_req && dm_req) begin
            if (last_q == LAST_IF) begin
                dm_win = 1'b1;
            end else begin
                if_win = 1'b1;
            end
        end else begin
            if_win = if_req;
            dm_win = dm_req;
        end
    end

    // Last-grant memory only moves on cycles where something was granted
    always_comb begin
        last_d = last_q;
        if (dm_win) begin
            last_d = LAST_DM;
        end else if (if_win) begin
            last_d = LAST_IF;
        end
    end

    // Last-grant register; starts at IF so the first conflict goes to dm
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= LAST_IF;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Fixed priority: the data port always beats instruction fetch
    always_comb begin
        dm_win = dm_req;
        if_win = if_req & ~dm_req;
    end
`endif

    // Grants are suppressed while reset is held so nothing leaks out early
    always_comb begin
        if_gnt = if_win & rst_n;
        dm_gnt = dm_win & rst_n;
    end

    // Steer the granted in-range access onto the RAM port, idle it otherwise
    always_comb begin
        ram_addr  = 16'h0000;
        ram_wdata = 16'h0000;
        ram_we    = 1'b0;
        if (dm_gnt && dm_in_range) begin
            ram_addr  = dm_addr;
            ram_wdata = dm_wdata;
            ram_we    = dm_we;
        end else if (if_gnt && if_in_range) begin
            ram_addr = if_addr;
        end
    end

    // Work out which port owns next cycle's read data and which one errors
    always_comb begin
        pend_d   = PEND_NONE;
        if_err_d = 1'b0;
        dm_err_d = 1'b0;
        if (dm_gnt) begin
            if (!dm_in_range) begin
                dm_err_d = 1'b1;
            end else if (!dm_we) begin
                pend_d = PEND_DM;
            end
        end else if (if_gnt) begin
            if (!if_in_range) begin
                if_err_d = 1'b1;
            end else begin
                pend_d = PEND_IF;
            end
        end
    end

    // Pending-read owner and error flags, cleared immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q   <= PEND_NONE;
            if_err_q <= 1'b0;
            dm_err_q <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            if_err_q <= if_err_d;
            dm_err_q <= dm_err_d;
        end
    end

    // Route RAM read data to the owning port; rdata is zero unless valid
    always_comb begin
        if_rvalid = (pend_q == PEND_IF);
        dm_rvalid = (pend_q == PEND_DM);
        if_rdata  = if_rvalid ? ram_rdata : 16'h0000;
        dm_rdata  = dm_rvalid ? ram_rdata : 16'h0000;
        if_err    = if_err_q;
        dm_err    = dm_err_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter.
// It has a behavioural RAM with a 1-cycle registered read.
// Expected responses are queued when a request is driven.
// They are popped and compared one cycle later.
module tb_mem_arbiter;

    localparam int MEM_WORDS = 512;

    typedef struct packed {
        logic        if_rvalid;
        logic [15:0] if_rdata;
        logic        if_err;
        logic        dm_rvalid;
        logic [15:0] dm_rdata;
        logic        dm_err;
    } resp_t;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [15:0] if_rdata;
    logic        if_err;
    logic        dm_req;
    logic        dm_we;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [15:0] dm_rdata;
    logic        dm_err;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic [15:0] ram_rdata;

    logic [15:0] ram [0:MEM_WORDS-1];
    logic [15:0] ref_mem [int];
    resp_t       exp_q [$];
    int          n_cmp;
    int          n_fail;

    mem_arbiter #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .if_err    (if_err),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_gnt    (dm_gnt),
        .dm_rvalid (dm_rvalid),
        .dm_rdata  (dm_rdata),
        .dm_err    (dm_err),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: write on the edge, registered read of the current address
    always @(posedge clk) begin
        if (ram_we) begin
            ram[ram_addr[8:0]] <= ram_wdata;
        end
        ram_rdata <= ram[ram_addr[8:0]];
    end

    // Time limit so a stuck run still reports and ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] time limit reached");
    end

    function automatic logic [15:0] ref_read(input logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0000;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare the response outputs against the oldest queued expectation
    task automatic check_output();
        resp_t e;
        e = '0;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
        end
        chk("if_rvalid", {15'd0, if_rvalid}, {15'd0, e.if_rvalid});
        chk("if_rdata",  if_rdata,           e.if_rdata);
        chk("if_err",    {15'd0, if_err},    {15'd0, e.if_err});
        chk("dm_rvalid", {15'd0, dm_rvalid}, {15'd0, e.dm_rvalid});
        chk("dm_rdata",  dm_rdata,           e.dm_rdata);
        chk("dm_err",    {15'd0, dm_err},    {15'd0, e.dm_err});
    endtask

    // One cycle: check last cycle's response, drive requests, check grant and RAM port
    task automatic apply_stimulus(input logic ir, input logic [15:0] ia,
                                  input logic dr, input logic dw,
                                  input logic [15:0] da, input logic [15:0] dwd,
                                  input logic exp_if_gnt, input logic exp_dm_gnt);
        resp_t       e;
        logic [15:0] ea;
        logic [15:0] ewd;
        logic        ewe;
        @(negedge clk);
        check_output();
        if_req   = ir;
        if_addr  = ia;
        dm_req   = dr;
        dm_we    = dw;
        dm_addr  = da;
        dm_wdata = dwd;
        #1;
        chk("if_gnt", {15'd0, if_gnt}, {15'd0, exp_if_gnt});
        chk("dm_gnt", {15'd0, dm_gnt}, {15'd0, exp_dm_gnt});
        e   = '0;
        ea  = 16'h0000;
        ewd = 16'h0000;
        ewe = 1'b0;
        if (exp_dm_gnt) begin
            if (int'(da) < MEM_WORDS) begin
                ea  = da;
                ewd = dwd;
                ewe = dw;
                if (dw) begin
                    ref_mem[int'(da)] = dwd;
                end else begin
                    e.dm_rvalid = 1'b1;
                    e.dm_rdata  = ref_read(da);
                end
            end else begin
                e.dm_err = 1'b1;
            end
        end else if (exp_if_gnt) begin
            if (int'(ia) < MEM_WORDS) begin
                ea          = ia;
                e.if_rvalid = 1'b1;
                e.if_rdata  = ref_read(ia);
            end else begin
                e.if_err = 1'b1;
            end
        end
        chk("ram_addr",  ram_addr,           ea);
        chk("ram_wdata", ram_wdata,          ewd);
        chk("ram_we",    {15'd0, ram_we},    {15'd0, ewe});
        exp_q.push_back(e);
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        for (int i = 0; i < MEM_WORDS; i++) begin
            ram[i] = 16'h0000;
        end
        ram_rdata = 16'h0000;
        rst_n     = 1'b0;
        if_req    = 1'b1;
        if_addr   = 16'h0001;
        dm_req    = 1'b1;
        dm_we     = 1'b1;
        dm_addr   = 16'h0002;
        dm_wdata  = 16'hFFFF;

        // Reset held with both ports requesting: everything must stay quiet
        repeat (2) @(negedge clk);
        chk("rst_if_gnt",    {15'd0, if_gnt},    16'h0000);
        chk("rst_dm_gnt",    {15'd0, dm_gnt},    16'h0000);
        chk("rst_ram_we",    {15'd0, ram_we},    16'h0000);
        chk("rst_if_rvalid", {15'd0, if_rvalid}, 16'h0000);
        chk("rst_dm_rvalid", {15'd0, dm_rvalid}, 16'h0000);
        chk("rst_if_err",    {15'd0, if_err},    16'h0000);
        chk("rst_dm_err",    {15'd0, dm_err},    16'h0000);
        if_req = 1'b0;
        dm_req = 1'b0;
        dm_we  = 1'b0;
        rst_n  = 1'b1;

        // Store then immediate load of the same word
        apply_stimulus(0, 16'h0000, 1, 1, 16'h0005, 16'h1234, 0, 1);
        apply_stimulus(0, 16'h0000, 1, 0, 16'h0005, 16'h0000, 0, 1);

        // Pre-store 0x0A00..0x0A03, then back-to-back fetches of them
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(0, 16'h0000, 1, 1, 16'(i), 16'h0A00 + 16'(i), 0, 1);
        end
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1, 16'(i), 0, 0, 16'h0000, 16'h0000, 1, 0);
        end
        apply_stimulus(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0);

        // Out-of-range fetch and out-of-range store, then a normal load
        apply_stimulus(1, 16'h0200, 0, 0, 16'h0000, 16'h0000, 1, 0);
        apply_stimulus(0, 16'h0000, 1, 1, 16'h0300, 16'hBEEF, 0, 1);
        apply_stimulus(0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 1);
        apply_stimulus(1, 16'h01FF, 0, 0, 16'h0000, 16'h0000, 1, 0);

        // Fetch alone leaves the round-robin pointer on IF, then 4 conflict cycles
        apply_stimulus(1, 16'h0003, 0, 0, 16'h0000, 16'h0000, 1, 0);
`ifdef MEM_ARB_RR_EN
        apply_stimulus(1, 16'h0001, 1, 0, 16'h0002, 16'h0000, 0, 1);
        apply_stimulus(1, 16'h0001, 1, 0, 16'h0002, 16'h0000, 1, 0);
        apply_stimulus(1, 16'h0001, 1, 0, 16'h0002, 16'h0000, 0, 1);
        apply_stimulus(1, 16'h0001, 1, 0, 16'h0002, 16'h0000, 1, 0);
`else
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1, 16'h0001, 1, 0, 16'h0002, 16'h0000, 0, 1);
        end
`endif

        // Read granted, then reset drops mid-cycle before the next edge
        apply_stimulus(1, 16'h0002, 0, 0, 16'h0000, 16'h0000, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_if_gnt",    {15'd0, if_gnt},    16'h0000);
        chk("midrst_ram_addr",  ram_addr,           16'h0000);
        chk("midrst_if_rvalid", {15'd0, if_rvalid}, 16'h0000);
        chk("midrst_dm_rvalid", {15'd0, dm_rvalid}, 16'h0000);
        if_req = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // After release: no stale rvalid, first conflict to dm, then policy-dependent
        apply_stimulus(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0);
        apply_stimulus(1, 16'h0003, 1, 0, 16'h0000, 16'h0000, 0, 1);
`ifdef MEM_ARB_RR_EN
        apply_stimulus(1, 16'h0003, 1, 0, 16'h0000, 16'h0000, 1, 0);
`else
        apply_stimulus(1, 16'h0003, 1, 0, 16'h0000, 16'h0000, 0, 1);
`endif
        apply_stimulus(1, 16'h0001, 0, 0, 16'h0000, 16'h0000, 1, 0);
        apply_stimulus(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0);
        @(negedge clk);
        check_output();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
